// File: rtl/pipe_pkg.sv
// Shared types for the core's stage-boundary registers: entry flags, per-stage payload
// layouts and the widths used to size each pipe_stage_reg instance.
package pipe_pkg;

    typedef struct packed {
        logic valid;
        logic nop;
    } pipe_flags_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] wb_val;
        logic [4:0]  rd;
        logic        reg_wr;
    } mem_wb_t;

    localparam int IF_ID_W  = $bits(if_id_t);
    localparam int ID_EX_W  = $bits(id_ex_t);
    localparam int EX_MEM_W = $bits(ex_mem_t);
    localparam int MEM_WB_W = $bits(mem_wb_t);

    // An empty entry reads as a bubble so downstream never mistakes it for work.
    localparam logic RST_NOP = 1'b1;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry (valid, nop, payload). Flush and reset restore the bubble state;
// unload only drops valid so the payload lines do not toggle on drain.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              load,
    input  logic              unload,
    input  logic              load_nop,
    input  logic [DATA_W-1:0] load_data,
    output logic              valid,
    output logic              nop,
    output logic [DATA_W-1:0] data
);

    pipe_flags_t flags;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags <= '{valid: 1'b0, nop: RST_NOP};
            data  <= RST_VAL;
        end else if (flush) begin
            flags <= '{valid: 1'b0, nop: RST_NOP};
            data  <= RST_VAL;
        end else if (load) begin
            flags <= '{valid: 1'b1, nop: load_nop};
            data  <= load_data;
        end else if (unload) begin
            flags.valid <= 1'b0;
        end
    end

    assign valid = flags.valid;
    assign nop   = flags.nop;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic stage-boundary register: main entry plus optional skid entry, valid/ready
// back-pressure, flush-to-bubble and registered occupancy for the hazard unit.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W  = 32,
    parameter int                SKID    = 1,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_nop,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic              out_nop,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occupancy
);

    logic              main_valid, main_nop;
    logic [DATA_W-1:0] main_data;
    logic              skid_valid, skid_nop;
    logic [DATA_W-1:0] skid_data;

    logic              accept, pop;
    logic              main_load, main_unload;
    logic              skid_load, skid_unload;
    logic              main_src_nop;
    logic [DATA_W-1:0] main_src_data;
    logic              main_valid_nxt, skid_valid_nxt;

    assign accept = in_valid & in_ready;
    assign pop    = main_valid & out_ready;

    // Refill main from the skid entry first; with skid full in_ready is low so the
    // input can never compete for the same slot.
    assign main_load     = (accept & (!main_valid | pop)) | (pop & skid_valid);
    assign main_unload   = pop & !main_load;
    assign main_src_nop  = skid_valid ? skid_nop  : in_nop;
    assign main_src_data = skid_valid ? skid_data : in_data;

    pipe_slot #(.DATA_W(DATA_W), .RST_VAL(RST_VAL)) u_main (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .load      (main_load),
        .unload    (main_unload),
        .load_nop  (main_src_nop),
        .load_data (main_src_data),
        .valid     (main_valid),
        .nop       (main_nop),
        .data      (main_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            assign skid_load   = accept & main_valid & !pop;
            assign skid_unload = pop & skid_valid;
            assign in_ready    = !skid_valid;

            pipe_slot #(.DATA_W(DATA_W), .RST_VAL(RST_VAL)) u_skid (
                .clk       (clk),
                .rst       (rst),
                .flush     (flush),
                .load      (skid_load),
                .unload    (skid_unload),
                .load_nop  (in_nop),
                .load_data (in_data),
                .valid     (skid_valid),
                .nop       (skid_nop),
                .data      (skid_data)
            );
        end else begin : g_no_skid
            assign skid_load   = 1'b0;
            assign skid_unload = 1'b0;
            assign skid_valid  = 1'b0;
            assign skid_nop    = RST_NOP;
            assign skid_data   = RST_VAL;
            assign in_ready    = !main_valid | out_ready;
        end
    endgenerate

    always_comb begin
        main_valid_nxt = main_valid;
        skid_valid_nxt = skid_valid;
        if (flush) begin
            main_valid_nxt = 1'b0;
            skid_valid_nxt = 1'b0;
        end else begin
            if (main_load)        main_valid_nxt = 1'b1;
            else if (main_unload) main_valid_nxt = 1'b0;
            if (skid_load)        skid_valid_nxt = 1'b1;
            else if (skid_unload) skid_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            occupancy <= 2'd0;
        else
            occupancy <= {main_valid_nxt & skid_valid_nxt, main_valid_nxt ^ skid_valid_nxt};
    end

    assign out_valid = main_valid;
    assign out_nop   = !main_valid | main_nop;
    assign out_data  = main_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid build for reset/stream/stall/flush/bubble,
// single-entry build for pass-through ready.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        flush = 1'b0, in_valid = 1'b0, in_nop = 1'b0, out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, out_valid, out_nop;
    logic [31:0] out_data;
    logic [1:0]  occupancy;

    logic        s0_flush = 1'b0, s0_in_valid = 1'b0, s0_in_nop = 1'b0, s0_out_ready = 1'b0;
    logic [31:0] s0_in_data = '0;
    logic        s0_in_ready, s0_out_valid, s0_out_nop;
    logic [31:0] s0_out_data;
    logic [1:0]  s0_occupancy;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .SKID(1), .RST_VAL(32'h0)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_nop(in_nop), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_nop(out_nop), .out_data(out_data),
        .out_ready(out_ready), .occupancy(occupancy)
    );

    pipe_stage_reg #(.DATA_W(32), .SKID(0), .RST_VAL(32'h0)) dut0 (
        .clk(clk), .rst(rst), .flush(s0_flush),
        .in_valid(s0_in_valid), .in_nop(s0_in_nop), .in_data(s0_in_data), .in_ready(s0_in_ready),
        .out_valid(s0_out_valid), .out_nop(s0_out_nop), .out_data(s0_out_data),
        .out_ready(s0_out_ready), .occupancy(s0_occupancy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1; in_nop = 1'b0; in_data = 32'h11; step();
        in_data   = 32'h22; step();
        in_valid  = 1'b0;
        checks++;
        if (occupancy !== 2'd2) begin
            fails++; $display("FAIL reset_pre_occ: got %0d want 2", occupancy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_nop !== 1'b1 || out_data !== 32'h0 ||
            in_ready !== 1'b1 || occupancy !== 2'd0) begin
            fails++;
            $display("FAIL reset_state: got v=%b n=%b d=%h r=%b o=%0d want v=0 n=1 d=0 r=1 o=0",
                     out_valid, out_nop, out_data, in_ready, occupancy);
        end
        @(negedge clk); rst = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            fails++; $display("FAIL reset_release: got v=%b o=%0d want v=0 o=0", out_valid, occupancy);
        end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_nop = 1'b0; in_data = i;
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== i || in_ready !== 1'b1 || occupancy !== 2'd1) begin
                fails++;
                $display("FAIL stream_%0d: got v=%b d=%h r=%b o=%0d want v=1 d=%h r=1 o=1",
                         i, out_valid, out_data, in_ready, occupancy, i);
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            fails++; $display("FAIL stream_drain: got v=%b o=%0d want v=0 o=0", out_valid, occupancy);
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid = 1'b1; in_nop = 1'b0; in_data = 32'hA;
        step();
        checks++;
        if (out_data !== 32'hA || occupancy !== 2'd1 || in_ready !== 1'b1) begin
            fails++; $display("FAIL stall_load_a: got d=%h o=%0d r=%b want d=a o=1 r=1", out_data, occupancy, in_ready);
        end
        in_data = 32'hB;
        step();
        in_valid = 1'b0;
        checks++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hA) begin
            fails++; $display("FAIL stall_skid: got o=%0d r=%b d=%h want o=2 r=0 d=a", occupancy, in_ready, out_data);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hA || occupancy !== 2'd2) begin
            fails++; $display("FAIL stall_hold: got v=%b d=%h o=%0d want v=1 d=a o=2", out_valid, out_data, occupancy);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hB || occupancy !== 2'd1 || in_ready !== 1'b1) begin
            fails++; $display("FAIL stall_pop_a: got v=%b d=%h o=%0d r=%b want v=1 d=b o=1 r=1",
                              out_valid, out_data, occupancy, in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            fails++; $display("FAIL stall_pop_b: got v=%b o=%0d want v=0 o=0", out_valid, occupancy);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h1; step();
        in_data = 32'h2; step();
        checks++;
        if (occupancy !== 2'd2) begin
            fails++; $display("FAIL flush_pre_occ: got %0d want 2", occupancy);
        end
        flush = 1'b1; in_valid = 1'b1; in_data = 32'hC; out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_nop !== 1'b1 || out_data !== 32'h0 ||
            occupancy !== 2'd0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_state: got v=%b n=%b d=%h o=%0d r=%b want v=0 n=1 d=0 o=0 r=1",
                     out_valid, out_nop, out_data, occupancy, in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || out_data === 32'hC) begin
            fails++; $display("FAIL flush_no_c: got v=%b d=%h want v=0 d!=c", out_valid, out_data);
        end
    endtask

    task automatic test_bubble();
        out_ready = 1'b1;
        in_valid = 1'b1; in_nop = 1'b1; in_data = 32'h55;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_nop !== 1'b1 || out_data !== 32'h55) begin
            fails++; $display("FAIL bubble_nop: got v=%b n=%b d=%h want v=1 n=1 d=55", out_valid, out_nop, out_data);
        end
        in_nop = 1'b0; in_data = 32'h66;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_nop !== 1'b0 || out_data !== 32'h66) begin
            fails++; $display("FAIL bubble_real: got v=%b n=%b d=%h want v=1 n=0 d=66", out_valid, out_nop, out_data);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || out_nop !== 1'b1) begin
            fails++; $display("FAIL bubble_empty: got v=%b n=%b want v=0 n=1", out_valid, out_nop);
        end
    endtask

    task automatic test_no_skid();
        s0_out_ready = 1'b0;
        s0_in_valid = 1'b1; s0_in_data = 32'h7;
        step();
        checks++;
        if (s0_out_valid !== 1'b1 || s0_out_data !== 32'h7 || s0_occupancy !== 2'd1 || s0_in_ready !== 1'b0) begin
            fails++; $display("FAIL noskid_full: got v=%b d=%h o=%0d r=%b want v=1 d=7 o=1 r=0",
                              s0_out_valid, s0_out_data, s0_occupancy, s0_in_ready);
        end
        s0_out_ready = 1'b1;
        #1;
        checks++;
        if (s0_in_ready !== 1'b1) begin
            fails++; $display("FAIL noskid_comb_ready: got %b want 1", s0_in_ready);
        end
        s0_in_data = 32'h8;
        step();
        checks++;
        if (s0_out_data !== 32'h8 || s0_occupancy !== 2'd1) begin
            fails++; $display("FAIL noskid_pass: got d=%h o=%0d want d=8 o=1", s0_out_data, s0_occupancy);
        end
        s0_out_ready = 1'b0; s0_in_data = 32'h9;
        step();
        step();
        s0_in_valid = 1'b0;
        checks++;
        if (s0_out_data !== 32'h8 || s0_occupancy !== 2'd1 || s0_in_ready !== 1'b0) begin
            fails++; $display("FAIL noskid_hold: got d=%h o=%0d r=%b want d=8 o=1 r=0",
                              s0_out_data, s0_occupancy, s0_in_ready);
        end
    endtask

    initial begin
        #12 rst = 1'b0;
        step();
        test_reset();
        test_streaming();
        test_stall();
        test_flush();
        test_bubble();
        test_no_skid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
